player_ship: RTL and testbench
==============================

PLAYER_SHIP -- requirements
Module: player_ship

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - POS_W, 10, width of hPos, vPos and gunPosition.
 - H_RES, 640, visible line width in pixels.
 - SHIP_W, 32, sprite width in pixels.
 - SHIP_H, 16, sprite height in pixels.
 - SHIP_Y, 430, sprite top row.
 - STEP, 4, pixels moved per frame_tick.
 - COOLDOWN, 8, frames between shots.
 - FLASH_FRAMES, 30, invulnerable frames after a hit.
 - LIVES, 3, lives at reset.
 - LIVES_W, 2, width of lives.
 - COLOR_W, 3, width of color.
 - SHIP_COLOR, 3'b010, normal sprite color.
 - HIT_COLOR, 3'b100, flash sprite color.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 - clk, in, 1, single clock; all logic on its rising edge.
 - reset, in, 1, synchronous, active-low.
 - frame_tick, in, 1, one-cycle pulse per video frame.
 - left, in, 1, move-left request.
 - right, in, 1, move-right request.
 - fire, in, 1, fire request.
 - hit, in, 1, ship struck, sampled every cycle.
 - hPos, in, POS_W, current pixel column.
 - vPos, in, POS_W, current pixel row.
 - gunPosition, out, POS_W, ship centre column, registered.
 - color, out, COLOR_W, ship pixel color, 0 when transparent.
 - shot, out, 1, one-cycle pulse when a shot launches.
 - lives, out, LIVES_W, remaining lives.
 - alive, out, 1, high unless in DEAD.

Function
REQ-003 Internal left-edge register x SHALL satisfy 0 <= x <= H_RES-SHIP_W at all times; gunPosition SHALL equal x+SHIP_W/2, updated in the cycle after x changes.
REQ-004 State machine SHALL have states ALIVE, FLASH and DEAD.
REQ-005 In ALIVE on frame_tick: left&~right -> x = max(0, x-STEP); right&~left -> x = min(H_RES-SHIP_W, x+STEP); both or neither -> x holds; saturating, never wrapping; arithmetic one bit wider than POS_W.
REQ-006 Movement and firing SHALL occur only on frame_tick and only in ALIVE; x SHALL hold in FLASH and DEAD.
REQ-007 In ALIVE on frame_tick with fire=1 and cooldown=0: shot=1 for exactly one cycle and cooldown loads COOLDOWN; fire with cooldown>0 SHALL be dropped, not queued.
REQ-008 The cooldown counter SHALL decrement on each frame_tick while nonzero, in every state.
REQ-009 hit in ALIVE with lives>1: lives decrements, flash counter loads FLASH_FRAMES, next state FLASH.
REQ-010 hit in ALIVE with lives=1: lives becomes 0, next state DEAD, alive=0 next cycle.
REQ-011 hit SHALL be ignored in FLASH and DEAD.
REQ-012 hit and frame_tick in the same ALIVE cycle: the hit is taken and the move and shot for that frame are suppressed.
REQ-013 FLASH SHALL decrement the flash counter on each frame_tick and return to ALIVE on the frame_tick at which the counter reaches 0.
REQ-014 DEAD SHALL be terminal until reset.
REQ-015 color SHALL be registered, giving 1-cycle latency from hPos/vPos.
REQ-016 color SHALL be computed inside the box x <= hPos < x+SHIP_W and SHIP_Y <= vPos < SHIP_Y+SHIP_H:
 - ALIVE: SHIP_COLOR.
 - FLASH: HIT_COLOR when flash-counter bit0=1, else 0.
 - DEAD: 0.
REQ-017 color SHALL be 0 outside the box; the box edges are inclusive-left/top and exclusive-right/bottom.

Reset
REQ-018 While reset=0 at a rising clk edge, the next cycle SHALL have:
 - x = (H_RES-SHIP_W)/2 and gunPosition = H_RES/2.
 - lives = LIVES and state ALIVE.
 - alive = 1, shot = 0, color = 0.
 - cooldown = 0 and flash counter = 0.
REQ-019 Reset SHALL override all inputs, including mid-FLASH, from DEAD, and with a frame_tick in the same cycle.

Verification
REQ-020 Bench SHALL cover, with default parameters:
 - Reset, then hold right for 100 frame_ticks -> gunPosition 320, rising by 4 per tick, saturates at 624 (x=608) and never wraps; left for 200 ticks -> 16.
 - left=right=1 for 10 ticks -> gunPosition unchanged.
 - fire held for 20 frame_ticks -> shot pulses on ticks 1, 10 and 19, each exactly 1 cycle wide.
 - hit pulse while ALIVE -> lives 3->2; color toggles HIT_COLOR/0 inside the box; a second hit during FLASH is ignored; ALIVE resumes after 30 ticks.
 - Three separated hits -> lives 0, alive=0, color 0 everywhere; reset restores lives 3 and gunPosition 320.
 - Raster sweep at x=304, vPos=430: color=SHIP_COLOR for hPos 304..335 one cycle later; 0 at hPos 303, at 336 and at vPos 446.

Source files
------------

// File: rtl/player_ship.sv
// Player ship: saturating horizontal movement, shot cooldown, hit/flash/death
// state machine and a registered sprite color for the raster.
module player_ship #(
  parameter int POS_W        = 10,
  parameter int H_RES        = 640,
  parameter int SHIP_W       = 32,
  parameter int SHIP_H       = 16,
  parameter int SHIP_Y       = 430,
  parameter int STEP         = 4,
  parameter int COOLDOWN     = 8,
  parameter int FLASH_FRAMES = 30,
  parameter int LIVES        = 3,
  parameter int LIVES_W      = 2,
  parameter int COLOR_W      = 3,
  parameter logic [COLOR_W-1:0] SHIP_COLOR = 3'b010,
  parameter logic [COLOR_W-1:0] HIT_COLOR  = 3'b100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               left,
  input  logic               right,
  input  logic               fire,
  input  logic               hit,
  input  logic [POS_W-1:0]   hPos,
  input  logic [POS_W-1:0]   vPos,
  output logic [POS_W-1:0]   gunPosition,
  output logic [COLOR_W-1:0] color,
  output logic               shot,
  output logic [LIVES_W-1:0] lives,
  output logic               alive
);

  typedef enum logic [1:0] {
    ALIVE,
    FLASH,
    DEAD
  } state_t;

  localparam int CD_W = $clog2(COOLDOWN + 1);
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);
  localparam int EW   = POS_W + 1;

  localparam logic [EW-1:0] X_MAX  = EW'(H_RES - SHIP_W);
  localparam logic [EW-1:0] X_RST  = EW'((H_RES - SHIP_W) / 2);
  localparam logic [EW-1:0] STEP_E = EW'(STEP);
  localparam logic [EW-1:0] W_E    = EW'(SHIP_W);
  localparam logic [EW-1:0] HALF_E = EW'(SHIP_W / 2);
  localparam logic [EW-1:0] Y_TOP  = EW'(SHIP_Y);
  localparam logic [EW-1:0] Y_BOT  = EW'(SHIP_Y + SHIP_H);

  state_t state, state_n;

  logic [POS_W-1:0]   x, x_n;
  logic [CD_W-1:0]    cd, cd_n;
  logic [FL_W-1:0]    fl, fl_n;
  logic [LIVES_W-1:0] lv, lv_n;
  logic               shot_n;
  logic [COLOR_W-1:0] color_n;

  logic [EW-1:0] xe;
  logic [EW-1:0] x_lft;
  logic [EW-1:0] x_rgt;
  logic [EW-1:0] x_sum;
  logic [EW-1:0] x_mv;

  logic [EW-1:0] he;
  logic [EW-1:0] ve;
  logic          in_h;
  logic          in_v;

  // Candidate positions, one bit wider so nothing can wrap.
  always_comb begin
    xe    = {1'b0, x};
    x_sum = xe + STEP_E;
    x_lft = (xe > STEP_E) ? xe - STEP_E : '0;
    x_rgt = (x_sum > X_MAX) ? X_MAX : x_sum;
    unique case (1'b1)
      (left & ~right): x_mv = x_lft;
      (right & ~left): x_mv = x_rgt;
      default:         x_mv = xe;
    endcase
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    cd_n    = cd;
    fl_n    = fl;
    lv_n    = lv;
    shot_n  = 1'b0;

    if (frame_tick && cd != '0)
      cd_n = cd - 1'b1;

    unique case (state)
      ALIVE: begin
        // A hit wins over the frame's move and shot.
        if (hit) begin
          if (lv > LIVES_W'(1)) begin
            lv_n    = lv - 1'b1;
            fl_n    = FL_W'(FLASH_FRAMES);
            state_n = FLASH;
          end else begin
            lv_n    = '0;
            state_n = DEAD;
          end
        end else if (frame_tick) begin
          x_n = x_mv[POS_W-1:0];
          if (fire && cd == '0) begin
            shot_n = 1'b1;
            cd_n   = CD_W'(COOLDOWN);
          end
        end
      end
      FLASH: begin
        if (frame_tick) begin
          if (fl <= FL_W'(1)) begin
            fl_n    = '0;
            state_n = ALIVE;
          end else begin
            fl_n = fl - 1'b1;
          end
        end
      end
      default: begin
        state_n = DEAD;
      end
    endcase
  end

  always_comb begin
    he      = {1'b0, hPos};
    ve      = {1'b0, vPos};
    in_h    = (he >= xe) && (he < xe + W_E);
    in_v    = (ve >= Y_TOP) && (ve < Y_BOT);
    color_n = '0;
    if (in_h && in_v) begin
      unique case (state)
        ALIVE:   color_n = SHIP_COLOR;
        FLASH:   color_n = fl[0] ? HIT_COLOR : '0;
        default: color_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ALIVE;
      x           <= X_RST[POS_W-1:0];
      gunPosition <= POS_W'(H_RES / 2);
      cd          <= '0;
      fl          <= '0;
      lv          <= LIVES_W'(LIVES);
      shot        <= 1'b0;
      color       <= '0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      gunPosition <= POS_W'(xe + HALF_E);
      cd          <= cd_n;
      fl          <= fl_n;
      lv          <= lv_n;
      shot        <= shot_n;
      color       <= color_n;
    end
  end

  assign lives = lv;
  assign alive = (state != DEAD);

endmodule

// File: tb/tb_player_ship.sv
// Bench for player_ship: directed scenarios plus randomized traffic
// against a frame-level behavioural model.
module tb_player_ship;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       fire = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] hPos = '0;
  logic [9:0] vPos = '0;
  logic [9:0] gunPosition;
  logic [2:0] color;
  logic       shot;
  logic [1:0] lives;
  logic       alive;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ship left edge, lives, frames of cooldown and
  // of invulnerability left, death flag, and expected registered outputs.
  int m_x, m_lives, m_cd, m_fl, m_gun, m_color;
  bit m_dead, m_shot;

  player_ship dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .left(left), .right(right), .fire(fire), .hit(hit),
    .hPos(hPos), .vPos(vPos), .gunPosition(gunPosition),
    .color(color), .shot(shot), .lives(lives), .alive(alive)
  );

  always #5 clk = ~clk;

  function automatic int box_color(int hp, int vp);
    if (hp < m_x || hp >= m_x + 32 || vp < 430 || vp >= 446) return 0;
    if (m_dead) return 0;
    if (m_fl > 0) return (m_fl % 2 == 1) ? 4 : 0;
    return 2;
  endfunction

  task automatic step(input bit rst_v, input bit ft, input bit l,
                      input bit r, input bit f, input bit h,
                      input int hp, input int vp);
    int cd_was;
    reset = rst_v; frame_tick = ft; left = l; right = r;
    fire = f; hit = h; hPos = hp[9:0]; vPos = vp[9:0];
    @(posedge clk);
    if (!rst_v) begin
      m_x = 304; m_gun = 320; m_lives = 3; m_cd = 0; m_fl = 0;
      m_dead = 0; m_shot = 0; m_color = 0;
    end else begin
      m_gun   = m_x + 16;
      m_color = box_color(hp, vp);
      m_shot  = 0;
      cd_was  = m_cd;
      if (ft && m_cd > 0) m_cd--;
      if (m_dead) begin
      end else if (m_fl > 0) begin
        if (ft) m_fl--;
      end else if (h) begin
        m_lives--;
        if (m_lives == 0) m_dead = 1;
        else m_fl = 30;
      end else if (ft) begin
        if (l && !r) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
        else if (r && !l) m_x = (m_x + 4 > 608) ? 608 : m_x + 4;
        if (f && cd_was == 0) begin
          m_shot = 1;
          m_cd = 8;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int hp = 0, input int vp = 0);
    step(1, 0, 0, 0, 0, 0, hp, vp);
  endtask

  task automatic tick(input bit l, input bit r, input bit f);
    step(1, 1, l, r, f, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 1, 1, 0, 1, 1, 310, 435);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (gunPosition !== 10'd320 || lives !== 2'd3 || alive !== 1'b1 ||
        shot !== 1'b0 || color !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: gun=%0d lives=%0d alive=%0b shot=%0b color=%0d, want 320 3 1 0 0",
               gunPosition, lives, alive, shot, color);
    end
    do_reset();
    idle(310, 435);
    n_tests++;
    if (color !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_alive_color: got %0d want 2", color);
    end
  endtask

  task automatic test_move();
    int e;
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      tick(0, 1, 0);
      idle();
      e = (320 + 4 * k > 624) ? 624 : 320 + 4 * k;
      n_tests++;
      if (gunPosition !== 10'(e)) begin
        n_fail++;
        $display("FAIL move_right[%0d]: got %0d want %0d", k, gunPosition, e);
      end
    end
    for (int k = 1; k <= 200; k++) begin
      tick(1, 0, 0);
      idle();
      e = (624 - 4 * k < 16) ? 16 : 624 - 4 * k;
      n_tests++;
      if (gunPosition !== 10'(e)) begin
        n_fail++;
        $display("FAIL move_left[%0d]: got %0d want %0d", k, gunPosition, e);
      end
    end
  endtask

  task automatic test_both();
    for (int k = 0; k < 10; k++) tick(0, 1, 0);
    idle();
    for (int k = 0; k < 10; k++) begin
      tick(1, 1, 0);
      idle();
      n_tests++;
      if (gunPosition !== 10'd56) begin
        n_fail++;
        $display("FAIL both_dirs[%0d]: got %0d want 56", k, gunPosition);
      end
    end
  endtask

  task automatic test_fire();
    bit e;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick(0, 0, 1);
      e = (k == 1 || k == 10 || k == 19);
      n_tests++;
      if (shot !== e) begin
        n_fail++;
        $display("FAIL fire_tick[%0d]: shot=%0b want %0b", k, shot, e);
      end
      step(1, 0, 0, 0, 1, 0, 0, 0);
      n_tests++;
      if (shot !== 1'b0) begin
        n_fail++;
        $display("FAIL fire_width[%0d]: shot=%0b want 0", k, shot);
      end
    end
  endtask

  task automatic test_hit_flash();
    int e;
    do_reset();
    step(1, 0, 0, 0, 0, 1, 0, 0);
    idle();
    n_tests++;
    if (lives !== 2'd2 || alive !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_lives: lives=%0d alive=%0b want 2 1", lives, alive);
    end
    for (int k = 1; k <= 30; k++) begin
      idle(310, 435);
      e = (k % 2 == 0) ? 4 : 0;
      n_tests++;
      if (color !== 3'(e)) begin
        n_fail++;
        $display("FAIL flash_color[%0d]: got %0d want %0d", k, color, e);
      end
      step(1, 1, 0, 1, 1, (k == 5), 0, 0);
    end
    idle(310, 435);
    n_tests++;
    if (lives !== 2'd2 || gunPosition !== 10'd320 || color !== 3'd2) begin
      n_fail++;
      $display("FAIL flash_end: lives=%0d gun=%0d color=%0d want 2 320 2",
               lives, gunPosition, color);
    end
    tick(0, 1, 0);
    idle();
    n_tests++;
    if (gunPosition !== 10'd324) begin
      n_fail++;
      $display("FAIL resume_move: got %0d want 324", gunPosition);
    end
  endtask

  task automatic test_death();
    do_reset();
    for (int h = 0; h < 3; h++) begin
      step(1, 0, 0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 31; k++) tick(0, 0, 0);
    end
    step(1, 1, 0, 0, 0, 1, 0, 0);
    idle();
    n_tests++;
    if (lives !== 2'd0 || alive !== 1'b0) begin
      n_fail++;
      $display("FAIL dead: lives=%0d alive=%0b want 0 0", lives, alive);
    end
    for (int hp = 296; hp < 344; hp += 4) begin
      idle(hp, 435);
      n_tests++;
      if (color !== 3'd0) begin
        n_fail++;
        $display("FAIL dead_color[%0d]: got %0d want 0", hp, color);
      end
    end
    do_reset();
    n_tests++;
    if (lives !== 2'd3 || gunPosition !== 10'd320 || alive !== 1'b1) begin
      n_fail++;
      $display("FAIL dead_reset: lives=%0d gun=%0d alive=%0b want 3 320 1",
               lives, gunPosition, alive);
    end
    step(1, 0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0);
    do_reset();
    idle(310, 435);
    n_tests++;
    if (lives !== 2'd3 || color !== 3'd2) begin
      n_fail++;
      $display("FAIL flash_reset: lives=%0d color=%0d want 3 2", lives, color);
    end
  endtask

  task automatic test_raster();
    int e;
    do_reset();
    for (int hp = 300; hp <= 340; hp++) begin
      idle(hp, 430);
      e = (hp >= 304 && hp <= 335) ? 2 : 0;
      n_tests++;
      if (color !== 3'(e)) begin
        n_fail++;
        $display("FAIL raster_h[%0d]: got %0d want %0d", hp, color, e);
      end
    end
    for (int vp = 428; vp <= 447; vp++) begin
      idle(320, vp);
      e = (vp >= 430 && vp <= 445) ? 2 : 0;
      n_tests++;
      if (color !== 3'(e)) begin
        n_fail++;
        $display("FAIL raster_v[%0d]: got %0d want %0d", vp, color, e);
      end
    end
  endtask

  task automatic test_random();
    bit rs, ft, l, r, f, h;
    int hp, vp;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rs = ($urandom_range(0, 299) != 0);
      ft = ($urandom_range(0, 2) == 0);
      l  = 1'($urandom);
      r  = ($urandom_range(0, 2) != 0);
      f  = 1'($urandom);
      h  = ($urandom_range(0, 59) == 0);
      hp = (c % 4 == 0) ? $urandom_range(0, 1023) : m_x + $urandom_range(0, 40) - 4;
      if (hp < 0) hp = 0;
      vp = $urandom_range(426, 449);
      step(rs, ft, l, r, f, h, hp, vp);
      n_tests++;
      if (gunPosition !== 10'(m_gun) || color !== 3'(m_color) ||
          shot !== m_shot || lives !== 2'(m_lives) || alive !== !m_dead) begin
        n_fail++;
        $display("FAIL random[%0d]: gun=%0d color=%0d shot=%0b lives=%0d alive=%0b, want %0d %0d %0b %0d %0b",
                 c, gunPosition, color, shot, lives, alive,
                 m_gun, m_color, m_shot, m_lives, !m_dead);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_both();
    test_fire();
    test_hit_flash();
    test_death();
    test_raster();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
